// File: rtl/blitter.sv
// Sprite/clear engine for the 1-bpp framebuffer.
// Sprite rows are XOR-blended into the framebuffer by read-modify-write.
module blitter (
   input  logic        clk,
   input  logic        reset,
   input  logic        hires,
   input  logic [2:0]  blit_op,
   input  logic [11:0] blit_src,
   input  logic [3:0]  blit_srcHeight,
   input  logic [6:0]  blit_destX,
   input  logic [5:0]  blit_destY,
   input  logic        blit_enable,
   output logic        busy,
   output logic        done,
   output logic        collision,
   output logic        mem_en,
   output logic [11:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic [9:0]  fb_addr,
   output logic        fb_we,
   output logic [7:0]  fb_wdata,
   input  logic [7:0]  fb_rdata
);

   typedef enum logic [3:0] {
      IDLE, CLR, S_ADDR, S_WAIT, S_DATA, F_WAIT,
      F_LW, F_RA, F_RWAIT, F_RW, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [11:0] src_q, src_d;
   logic [3:0]  h_q, h_d;
   logic [6:0]  x_q, x_d;
   logic [5:0]  y_q, y_d;
   logic        hires_q, hires_d;
   logic [3:0]  row_q, row_d;
   logic [15:0] shifted_q, shifted_d;
   logic [9:0]  clr_q, clr_d;
   logic        coll_q, coll_d;

   logic [6:0]  ys;
   logic [9:0]  left_addr;
   logic        right_ok;
   logic        last_row;
   logic        clr_last;
   logic [15:0] shift_in;

   assign ys        = {1'b0, y_q} + {3'b000, row_q};
   assign left_addr = hires_q ? {ys[5:0], x_q[6:3]}
                              : {2'b00, ys[4:0], x_q[5:3]};
   // Right byte exists only when unaligned and not past the right edge.
   assign right_ok  = (x_q[2:0] != 3'd0) &&
                      (hires_q ? (x_q[6:3] != 4'hF) : (x_q[5:3] != 3'h7));
   assign last_row  = (({1'b0, row_q} + 5'd1) == {1'b0, h_q}) ||
                      ((ys + 7'd1) >= (hires_q ? 7'd64 : 7'd32));
   assign clr_last  = hires_q ? (clr_q == 10'd1023) : (clr_q == 10'd255);
   assign shift_in  = {mem_rdata, 8'h00} >> x_q[2:0];
   assign collision = coll_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         src_q     <= '0;
         h_q       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         hires_q   <= 1'b0;
         row_q     <= '0;
         shifted_q <= '0;
         clr_q     <= '0;
         coll_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         h_q       <= h_d;
         x_q       <= x_d;
         y_q       <= y_d;
         hires_q   <= hires_d;
         row_q     <= row_d;
         shifted_q <= shifted_d;
         clr_q     <= clr_d;
         coll_q    <= coll_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      h_d       = h_q;
      x_d       = x_q;
      y_d       = y_q;
      hires_d   = hires_q;
      row_d     = row_q;
      shifted_d = shifted_q;
      clr_d     = clr_q;
      coll_d    = coll_q;
      busy      = 1'b1;
      done      = 1'b0;
      mem_en    = 1'b0;
      mem_addr  = 12'h000;
      fb_addr   = 10'h000;
      fb_we     = 1'b0;
      fb_wdata  = 8'h00;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (blit_enable) begin
               src_d   = blit_src;
               h_d     = blit_srcHeight;
               hires_d = hires;
               x_d     = hires ? blit_destX : {1'b0, blit_destX[5:0]};
               y_d     = hires ? blit_destY : {1'b0, blit_destY[4:0]};
               row_d   = 4'd0;
               clr_d   = 10'd0;
               coll_d  = 1'b0;
               if (blit_op == 3'd1)
                  state_d = CLR;
               else if (blit_op == 3'd2 && blit_srcHeight != 4'd0)
                  state_d = S_ADDR;
               else
                  state_d = DONE;
            end
         end
         CLR: begin
            fb_addr = clr_q;
            fb_we   = 1'b1;
            clr_d   = clr_q + 10'd1;
            if (clr_last)
               state_d = DONE;
         end
         S_ADDR, S_WAIT: begin
            mem_en   = 1'b1;
            mem_addr = src_q + {8'h00, row_q};
            state_d  = (state_q == S_ADDR) ? S_WAIT : S_DATA;
         end
         S_DATA: begin
            mem_en    = 1'b1;
            mem_addr  = src_q + {8'h00, row_q};
            shifted_d = shift_in;
            fb_addr   = left_addr;
            state_d   = F_WAIT;
         end
         F_WAIT: begin
            fb_addr = left_addr;
            state_d = F_LW;
         end
         F_LW: begin
            fb_addr  = left_addr;
            fb_we    = 1'b1;
            fb_wdata = fb_rdata ^ shifted_q[15:8];
            coll_d   = coll_q | (|(fb_rdata & shifted_q[15:8]));
            if (right_ok)
               state_d = F_RA;
            else if (last_row)
               state_d = DONE;
            else begin
               row_d   = row_q + 4'd1;
               state_d = S_ADDR;
            end
         end
         F_RA, F_RWAIT: begin
            fb_addr = left_addr + 10'd1;
            state_d = (state_q == F_RA) ? F_RWAIT : F_RW;
         end
         F_RW: begin
            fb_addr  = left_addr + 10'd1;
            fb_we    = 1'b1;
            fb_wdata = fb_rdata ^ shifted_q[7:0];
            coll_d   = coll_q | (|(fb_rdata & shifted_q[7:0]));
            if (last_row)
               state_d = DONE;
            else begin
               row_d   = row_q + 4'd1;
               state_d = S_ADDR;
            end
         end
         DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule
